// File: rtl/fft_frame_port.sv
// Host-facing sequencer for the FFT frame protocol: loads a 512-beat frame into the
// banked buffer, kicks the core, then streams results back out on Q0..Q7 under DONE.
module fft_frame_port #(
    parameter int W     = 64,
    parameter int LANES = 8,
    parameter int BEATS = 512,
    parameter int AW    = 9
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    input  logic                 START,
    output logic                 DONE,
    input  logic [W-1:0]         D0,
    input  logic [W-1:0]         D1,
    input  logic [W-1:0]         D2,
    input  logic [W-1:0]         D3,
    input  logic [W-1:0]         D4,
    input  logic [W-1:0]         D5,
    input  logic [W-1:0]         D6,
    input  logic [W-1:0]         D7,
    output logic [W-1:0]         Q0,
    output logic [W-1:0]         Q1,
    output logic [W-1:0]         Q2,
    output logic [W-1:0]         Q3,
    output logic [W-1:0]         Q4,
    output logic [W-1:0]         Q5,
    output logic [W-1:0]         Q6,
    output logic [W-1:0]         Q7,
    output logic                 BUF_WE,
    output logic [AW-1:0]        BUF_WA,
    output logic [LANES*W-1:0]   BUF_WD,
    output logic                 BUF_RE,
    output logic [AW-1:0]        BUF_RA,
    input  logic [LANES*W-1:0]   BUF_RD,
    output logic                 CORE_GO,
    input  logic                 CORE_DONE
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] KICK  = 3'd2;
    localparam logic [2:0] WAIT  = 3'd3;
    localparam logic [2:0] PRIME = 3'd4;
    localparam logic [2:0] OUT   = 3'd5;
    localparam logic [2:0] DRAIN = 3'd6;
    localparam logic [2:0] REARM = 3'd7;

    localparam logic [AW-1:0] LAST_BEAT = AW'(BEATS - 1);

    logic [2:0]         state;
    logic [2:0]         state_nx;
    logic [AW-1:0]      cnt;
    logic               last_beat;
    logic [LANES*W-1:0] din;
    logic [LANES*W-1:0] q_all;

    assign last_beat = (cnt == LAST_BEAT);
    assign din       = {D7, D6, D5, D4, D3, D2, D1, D0};

    // NOTE: state_nx takes its default first so no path through the case leaves it unassigned (no latch).
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (START)     state_nx = LOAD;
            LOAD:    if (last_beat) state_nx = KICK;
            KICK:                   state_nx = WAIT;
            WAIT:    if (CORE_DONE) state_nx = PRIME;
            PRIME:                  state_nx = OUT;
            OUT:     if (last_beat) state_nx = DRAIN;
            DRAIN:                  state_nx = REARM;
            REARM:   if (!START)    state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    // The beat counter restarts on every phase change, so LOAD and OUT both begin at beat 0.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if (state_nx != state)
                cnt <= '0;
            else if (state == LOAD || state == OUT)
                cnt <= cnt + 1'b1;
        end
    end

    // Result register: captures the beat whose read was issued in the previous cycle.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn)
            q_all <= '0;
        else if (state == OUT)
            q_all <= BUF_RD;
    end

    assign BUF_WE  = (state == LOAD);
    assign BUF_WA  = BUF_WE ? cnt : '0;
    assign BUF_WD  = BUF_WE ? din : '0;

    // Reads run one beat ahead of the result register; the final OUT cycle issues none.
    assign BUF_RE  = (state == PRIME) || (state == OUT && !last_beat);
    assign BUF_RA  = (state == OUT && !last_beat) ? cnt + 1'b1 : '0;

    assign CORE_GO = (state == KICK);
    assign DONE    = (state == OUT);

    assign Q0 = q_all[0*W +: W];
    assign Q1 = q_all[1*W +: W];
    assign Q2 = q_all[2*W +: W];
    assign Q3 = q_all[3*W +: W];
    assign Q4 = q_all[4*W +: W];
    assign Q5 = q_all[5*W +: W];
    assign Q6 = q_all[6*W +: W];
    assign Q7 = q_all[7*W +: W];

endmodule

// File: tb/tb_fft_frame_port.sv
// Directed frame sequences with random sample data, checked cycle by cycle against a
// buffer model and the host-visible protocol rules.
module tb_fft_frame_port;

    logic         CLK = 1'b0;
    logic         RSTn;
    logic         START;
    logic         CORE_DONE;
    logic [63:0]  d [8];
    logic [63:0]  q [8];
    logic         DONE, BUF_WE, BUF_RE, CORE_GO;
    logic [8:0]   BUF_WA, BUF_RA;
    logic [511:0] BUF_WD;
    logic [511:0] BUF_RD;
    logic [511:0] q_all;

    logic [511:0] wmem   [512];
    logic [511:0] exp_wd [512];
    logic [511:0] q_exp;
    logic [31:0]  rd_salt;
    int           n_checks = 0;
    int           n_fail   = 0;
    bit           aborted;

    always #5 CLK = ~CLK;

    fft_frame_port dut (
        .CLK(CLK), .RSTn(RSTn), .START(START), .DONE(DONE),
        .D0(d[0]), .D1(d[1]), .D2(d[2]), .D3(d[3]),
        .D4(d[4]), .D5(d[5]), .D6(d[6]), .D7(d[7]),
        .Q0(q[0]), .Q1(q[1]), .Q2(q[2]), .Q3(q[3]),
        .Q4(q[4]), .Q5(q[5]), .Q6(q[6]), .Q7(q[7]),
        .BUF_WE(BUF_WE), .BUF_WA(BUF_WA), .BUF_WD(BUF_WD),
        .BUF_RE(BUF_RE), .BUF_RA(BUF_RA), .BUF_RD(BUF_RD),
        .CORE_GO(CORE_GO), .CORE_DONE(CORE_DONE)
    );

    always_comb begin
        q_all = '0;
        for (int i = 0; i < 8; i++) q_all[64*i +: 64] = q[i];
    end

    // Result contents the core is assumed to have left in the buffer: address-coded per frame.
    function automatic logic [511:0] rd_beat(input int a, input logic [31:0] salt);
        logic [511:0] r;
        for (int i = 0; i < 8; i++) r[64*i +: 64] = {salt + 32'(a), 32'(8 * a + i)};
        return r;
    endfunction

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [511:0] pack_d();
        logic [511:0] r;
        for (int i = 0; i < 8; i++) r[64*i +: 64] = d[i];
        return r;
    endfunction

    // Buffer model: write port stores, read port answers one cycle later, garbage otherwise.
    always @(posedge CLK) begin
        if (BUF_WE) wmem[BUF_WA] <= BUF_WD;
        if (BUF_RE) BUF_RD <= rd_beat(int'(BUF_RA), rd_salt);
        else        BUF_RD <= rnd512();
    end

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctl"}, 512'({DONE, BUF_WE, BUF_RE, CORE_GO}), '0);
        check({tag, "_wa"},  512'(BUF_WA), '0);
        check({tag, "_ra"},  512'(BUF_RA), '0);
        check({tag, "_wd"},  BUF_WD, '0);
        check({tag, "_q"},   q_all, '0);
    endtask

    task automatic hit_reset(input string tag);
        RSTn = 1'b0;
        START = 1'b0;
        CORE_DONE = 1'b0;
        #1;
        check_zero({tag, "_now"});
        step();
        check_zero({tag, "_next"});
        RSTn = 1'b1;
        q_exp = '0;
    endtask

    // Ends in the KICK cycle unless aborted by reset at beat abort_at.
    task automatic do_load(input bit seq_d, input int drop_at, input int cdone_at,
                           input int abort_at, output bit ab);
        int bad;
        ab = 1'b0;
        START = 1'b0;
        step();
        START = 1'b1;
        step();
        for (int k = 0; k < 512; k++) begin
            for (int i = 0; i < 8; i++) d[i] = seq_d ? 64'(8 * k + i) : {$urandom, $urandom};
            if (k == drop_at) START = 1'b0;
            CORE_DONE = (k == cdone_at);
            #1;
            exp_wd[k] = pack_d();
            check("load_we", 512'(BUF_WE), 512'(1));
            check("load_wa", 512'(BUF_WA), 512'(k));
            check("load_wd", BUF_WD, exp_wd[k]);
            check("load_go_done", 512'({CORE_GO, DONE}), '0);
            if (seq_d && k == 5) check("wd_beat5_lane3", 512'(BUF_WD[3*64 +: 64]), 512'(43));
            if (k == abort_at) begin
                hit_reset("rst_load");
                ab = 1'b1;
                break;
            end
            step();
        end
        if (ab) return;
        CORE_DONE = 1'b0;
        check("kick_go", 512'(CORE_GO), 512'(1));
        check("kick_we", 512'(BUF_WE), '0);
        check("kick_q_hold", q_all, q_exp);
        bad = 0;
        for (int k = 0; k < 512; k++) if (wmem[k] !== exp_wd[k]) bad++;
        check("frame_written", 512'(bad), '0);
    endtask

    // From KICK: holds CORE_DONE off for 'delay' WAIT cycles, ends in OUT beat 0.
    task automatic do_core(input int delay);
        step();
        check("wait_go_low", 512'(CORE_GO), '0);
        for (int i = 0; i < delay; i++) begin
            check("wait_done_low", 512'(DONE), '0);
            step();
        end
        CORE_DONE = 1'b1;
        step();
        CORE_DONE = 1'b0;
        check("prime_done_low", 512'(DONE), '0);
        check("prime_re", 512'(BUF_RE), 512'(1));
        check("prime_ra", 512'(BUF_RA), '0);
        step();
        check("done_rise_2cyc", 512'(DONE), 512'(1));
    endtask

    // Host capture: after the DONE-rise edge, each following edge (through DONE fall) yields one beat.
    task automatic do_out(input int abort_at, output bit ab);
        ab = 1'b0;
        for (int j = 0; j < 512; j++) begin
            check("out_done", 512'(DONE), 512'(1));
            check("out_re", 512'(BUF_RE), 512'(j < 511));
            if (j < 511) check("out_ra", 512'(BUF_RA), 512'(j + 1));
            check("out_q", q_all, q_exp);
            if (j == abort_at) begin
                hit_reset("rst_out");
                ab = 1'b1;
                break;
            end
            q_exp = rd_beat(j, rd_salt);
            step();
        end
        if (ab) return;
        check("drain_done_low", 512'(DONE), '0);
        check("q_last_beat", q_all, rd_beat(511, rd_salt));
        step();
        check("rearm_q_hold", q_all, q_exp);
        check("rearm_ctl", 512'({DONE, BUF_WE, BUF_RE, CORE_GO}), '0);
    endtask

    initial begin
        RSTn = 1'b0;
        START = 1'b0;
        CORE_DONE = 1'b0;
        for (int i = 0; i < 8; i++) d[i] = '0;
        q_exp = '0;
        rd_salt = '0;

        repeat (2) @(posedge CLK);
        #1;
        check_zero("reset");
        RSTn = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            check_zero("idle");
        end

        // Frame A: index-coded samples, immediate core, START held high afterwards.
        do_load(1'b1, -1, -1, -1, aborted);
        rd_salt = $urandom;
        do_core(0);
        do_out(-1, aborted);
        for (int c = 0; c < 20; c++) begin
            step();
            check("rearm_no_reload", 512'({BUF_WE, DONE, CORE_GO}), '0);
        end

        // Frame B: START dropped and a stray CORE_DONE mid-load, both ignored.
        do_load(1'b0, 100, 50, -1, aborted);
        rd_salt = $urandom;
        do_core(1);
        do_out(-1, aborted);

        // Frame C: long core latency.
        do_load(1'b0, -1, -1, -1, aborted);
        rd_salt = $urandom;
        do_core(1000);
        do_out(-1, aborted);

        // Reset during load, then a clean frame reset during output, then a clean frame.
        do_load(1'b0, -1, -1, 200, aborted);
        check("aborted_load", 512'(aborted), 512'(1));
        do_load(1'b0, -1, -1, -1, aborted);
        rd_salt = $urandom;
        do_core($urandom_range(0, 5));
        do_out(300, aborted);
        check("aborted_out", 512'(aborted), 512'(1));
        do_load(1'b0, -1, -1, -1, aborted);
        rd_salt = $urandom;
        do_core($urandom_range(0, 5));
        do_out(-1, aborted);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_frame_port.md
Name: fft_frame_port

Overview:
- DUT-side responder for the FFT frame protocol. The host drives START, streams 512 beats of 8x64-bit samples on D0..D7, then captures 512 result beats on Q0..Q7 while DONE is high.
- The block sequences that protocol.
- It writes incoming beats into an external banked frame buffer and hands the frame to the FFT core via a GO/DONE handshake.
- It reads results back out of the buffer and presents them on Q0..Q7 with the exact timing the host capture logic requires.

Parameters:
- W, 64, lane width in bits (32-bit re / 32-bit im packed).
- LANES, 8, samples per beat (fixed; ports D0..D7, Q0..Q7).
- BEATS, 512, beats per frame (4096 points / 8).
- AW, 9, beat address width, equal to log2(BEATS).

Ports:
- CLK  in  1  clock.
- RSTn  in  1  asynchronous active-low reset.
- START  in  1  host frame request (level).
- DONE  out  1  high for exactly BEATS cycles during result phase.
- D0..D7  in  64 each  input beat lanes; lane i = point 8*beat+i.
- Q0..Q7  out  64 each  result beat lanes, registered.
- BUF_WE  out  1  frame buffer write strobe.
- BUF_WA  out  AW  write beat address.
- BUF_WD  out  512  {D7..D0} packed; lane i at bits [64i+63:64i].
- BUF_RE  out  1  frame buffer read strobe.
- BUF_RA  out  AW  read beat address.
- BUF_RD  in  512  read data, valid exactly 1 cycle after BUF_RE.
- CORE_GO  out  1  one-cycle pulse: frame loaded, start transform.
- CORE_DONE  in  1  one-cycle pulse from core: results in buffer.

Behaviour:
- Reset values:
  - State is IDLE.
  - DONE, BUF_WE, BUF_RE and CORE_GO are 0.
  - BUF_WA, BUF_RA and Q0..Q7 are 0.
  - The beat counter is 0.
- States: IDLE, LOAD, KICK, WAIT, PRIME, OUT, DRAIN, REARM.
- IDLE: START sampled 1 at a rising edge -> LOAD. Beat 0 is the D value at the next edge.
- LOAD, cycle k (k = 0..511):
  - BUF_WE=1, BUF_WA=k, BUF_WD=current D0..D7 (combinational pass-through).
  - Counter increments.
  - At k=511 -> KICK.
  - START is not rechecked during LOAD; a START drop mid-load is ignored.
- KICK: CORE_GO=1 for one cycle -> WAIT.
- WAIT:
  - Hold until CORE_DONE=1 -> PRIME.
  - A CORE_DONE pulse outside WAIT is ignored.
  - There is no timeout.
- PRIME: BUF_RE=1, BUF_RA=0, DONE=0 -> OUT.
- OUT, cycle j (j = 0..511):
  - DONE=1.
  - BUF_RE=1 and BUF_RA=j+1 for j<511; BUF_RE=0 at j=511.
  - At the end of each OUT cycle, Q0..Q7 <= BUF_RD lanes (beat j). Beat j is therefore visible on Q in cycle j+1.
  - After j=511 -> DRAIN.
- DRAIN:
  - DONE=0.
  - Q holds beat 511 and is not reloaded.
  - Next state: REARM.
- REARM: wait for START=0, then -> IDLE. A START still high does not trigger a second frame.
- Q holds its last value in all states except OUT.
- Counter: AW bits, cleared on entry to LOAD and to OUT, no wrap inside a phase.
- Reset mid-operation: immediate return to reset values; no partial CORE_GO or DONE is emitted.

Test Plan:
- Reset/idle: RSTn=0, then 1 with START=0 for 20 cycles -> DONE, BUF_WE, CORE_GO and Q all stay 0.
- Load: START=1, D lanes = 8*beat+i -> 512 writes; BUF_WA runs 0..511; BUF_WD at beat 5 lane 3 = 43. CORE_GO pulses once in the cycle after WA=511.
- Core latency: CORE_DONE delayed 0, 1 and 1000 cycles after CORE_GO -> DONE rises exactly 2 cycles after CORE_DONE. CORE_DONE pulsed during LOAD -> no effect.
- Result timing with a buffer model (data = address pattern):
  - DONE is high for exactly 512 cycles.
  - The host capture rule (sample Q at every edge after the DONE-rise edge, up to and including the DONE-fall edge) yields beats 0..511 in order.
  - Q after DONE falls = beat 511.
- Rearm: START held high through completion -> no second LOAD. START low for 1 cycle then high -> second frame runs correctly.
- Reset mid-LOAD (beat 200) and mid-OUT (beat 300) -> all outputs 0 next cycle. A following START gives a clean frame with BUF_WA starting at 0.
